// File: rtl/voice_allocator.sv
// Two-voice key allocator: synchronizes eight async keys and services one press/release per cycle.
// Optional VOICE_ALLOCATOR_STEAL_EN: a press with both voices busy steals the older voice instead of dropping.
module voice_allocator #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  keys,
    output logic [11:0] channel1_pitch,
    output logic [11:0] channel2_pitch,
    output logic        channel1_ena,
    output logic        channel2_ena,
    output logic        dropped
);

    logic [7:0]  sync_q [SYNC_STAGES];
    logic [7:0]  prev_q;
    logic [7:0]  pend_press;
    logic [7:0]  pend_rel;
    logic [1:0]  busy;
    logic [2:0]  owner [2];
    logic [11:0] pitch_q [2];
`ifdef VOICE_ALLOCATOR_STEAL_EN
    logic        newest;
`endif

    logic [7:0] key_sync, rise, fall, cancel, press_done, rel_done;
    logic       svc_valid, svc_rel;
    logic [2:0] svc_key;
    logic [1:0] own_hit;
    logic       alloc_en, alloc_v, drop_now;

    function automatic logic [11:0] pitch_of(input logic [2:0] k);
        case (k)
            3'd0:    pitch_of = 12'd89;
            3'd1:    pitch_of = 12'd79;
            3'd2:    pitch_of = 12'd70;
            3'd3:    pitch_of = 12'd67;
            3'd4:    pitch_of = 12'd59;
            3'd5:    pitch_of = 12'd52;
            3'd6:    pitch_of = 12'd47;
            default: pitch_of = 12'd44;
        endcase
    endfunction

    assign key_sync = sync_q[SYNC_STAGES-1];
    assign rise     = key_sync & ~prev_q;
    assign fall     = ~key_sync & prev_q;

    // Releases beat presses; the descending loop leaves the lowest set index in svc_key.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        svc_valid = 1'b0;
        svc_rel   = 1'b0;
        svc_key   = 3'd0;
        if (|pend_rel) begin
            svc_valid = 1'b1;
            svc_rel   = 1'b1;
            for (int i = 7; i >= 0; i--)
                if (pend_rel[i]) svc_key = 3'(i);
        end else if (|pend_press) begin
            svc_valid = 1'b1;
            for (int i = 7; i >= 0; i--)
                if (pend_press[i]) svc_key = 3'(i);
        end
    end

    assign press_done = (svc_valid && !svc_rel) ? (8'b1 << svc_key) : 8'b0;
    assign rel_done   = (svc_valid &&  svc_rel) ? (8'b1 << svc_key) : 8'b0;
    // A press being serviced right now is no longer cancellable; its release must queue.
    assign cancel     = fall & pend_press & ~press_done;

    assign own_hit[0] = busy[0] && (owner[0] == svc_key);
    assign own_hit[1] = busy[1] && (owner[1] == svc_key);

    always_comb begin
        alloc_en = 1'b0;
        alloc_v  = 1'b0;
        drop_now = 1'b0;
        if (svc_valid && !svc_rel && (own_hit == 2'b00)) begin
            if (!busy[0]) begin
                alloc_en = 1'b1;
            end else if (!busy[1]) begin
                alloc_en = 1'b1;
                alloc_v  = 1'b1;
            end else begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
                alloc_en = 1'b1;
                alloc_v  = ~newest;
`else
                drop_now = 1'b1;
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'd0;
            prev_q     <= 8'd0;
            pend_press <= 8'd0;
            pend_rel   <= 8'd0;
            busy       <= 2'b00;
            owner[0]   <= 3'd0;
            owner[1]   <= 3'd0;
            pitch_q[0] <= 12'd0;
            pitch_q[1] <= 12'd0;
            dropped    <= 1'b0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
            newest     <= 1'b0;
`endif
        end else begin
            sync_q[0] <= keys;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q     <= key_sync;
            pend_press <= (pend_press & ~press_done & ~cancel) | rise;
            pend_rel   <= (pend_rel & ~rel_done) | (fall & ~cancel);
            dropped    <= drop_now;
            for (int v = 0; v < 2; v++)
                if (svc_rel && own_hit[v]) busy[v] <= 1'b0;
            if (alloc_en) begin
                busy[alloc_v]    <= 1'b1;
                owner[alloc_v]   <= svc_key;
                pitch_q[alloc_v] <= pitch_of(svc_key);
`ifdef VOICE_ALLOCATOR_STEAL_EN
                newest           <= alloc_v;
`endif
            end
        end
    end

    assign channel1_pitch = pitch_q[0];
    assign channel2_pitch = pitch_q[1];
    assign channel1_ena   = busy[0];
    assign channel2_ena   = busy[1];

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of key synchronizer flops; legal values are 2 or more.
REQ-002 Port clk, input, 1 bit: the single clock for the block.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port keys, input, 8 bits: asynchronous key levels, where 1 means pressed; bit k is key k.
REQ-005 Port channel1_pitch, output, 12 bits: pitch divider count for voice 1.
REQ-006 Port channel2_pitch, output, 12 bits: pitch divider count for voice 2.
REQ-007 Port channel1_ena, output, 1 bit: enable for voice 1.
REQ-008 Port channel2_ena, output, 1 bit: enable for voice 2.
REQ-009 Port dropped, output, 1 bit: one-cycle pulse when a press is discarded.

Function
REQ-010 Each keys bit SHALL pass through SYNC_STAGES flops; a prev register SHALL hold the last synchronized value.
REQ-011 A synchronized 0->1 change SHALL set pend_press[k]; a 1->0 change SHALL set pend_rel[k].
REQ-012 A release edge arriving while pend_press[k] is set SHALL clear pend_press[k] and SHALL NOT set pend_rel[k]; that key's press is never serviced.
REQ-013 The block SHALL service exactly one pending event per cycle, choosing by priority:
- any pend_rel before any pend_press;
- within a class, the lowest key index first.
REQ-014 Servicing SHALL clear the chosen pending bit in the same cycle; an edge detected in that same cycle for a different key SHALL still be recorded.
REQ-015 Each voice v SHALL hold a busy bit and a 3-bit owner key; channelN_ena SHALL equal busy of voice N.
REQ-016 Press of key k SHALL allocate as follows:
- voice 1 if free, else voice 2 if free;
- on allocation: busy=1, owner=k, channelN_pitch=PITCH[k];
- the newest flag SHALL then mark that voice.
REQ-017 Press of key k while that key already owns a voice SHALL be ignored.
REQ-018 Release of key k SHALL clear busy of the voice whose owner is k; if no voice owns k, nothing happens. channelN_pitch SHALL hold its value after release.
REQ-019 PITCH SHALL be fixed: k0..k7 = 89, 79, 70, 67, 59, 52, 47, 44 (C4 D4 E4 F4 G4 A4 B4 C5).
REQ-020 All outputs SHALL be registered.
REQ-021 Latency SHALL be SYNC_STAGES+2 rising edges from a keys change to the corresponding output change, for an uncontended event.
REQ-022 dropped SHALL pulse for exactly one cycle, coincident with the service cycle of the discarded press.

Reset
REQ-023 While rst=1, all synchronizer flops, prev, pending bits, busy bits, owners and the newest flag SHALL be 0.
REQ-024 While rst=1, channel1_pitch and channel2_pitch SHALL be 0, and channel1_ena, channel2_ena and dropped SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard all pending events immediately.
REQ-026 A key held through reset deassertion SHALL be treated as a new press (prev=0).

Configuration
REQ-027 The macro VOICE_ALLOCATOR_STEAL_EN SHALL select the behaviour of a press when both voices are busy.
REQ-028 With VOICE_ALLOCATOR_STEAL_EN defined:
- the voice not marked newest SHALL be reassigned to the pressing key (owner and pitch updated, ena stays 1);
- newest SHALL then mark that voice;
- dropped SHALL stay 0.
REQ-029 Without VOICE_ALLOCATOR_STEAL_EN, the press SHALL be discarded, dropped SHALL pulse, and voice state SHALL be unchanged.

Verification
REQ-030 Press key0 only (SYNC_STAGES=2) -> after 4 edges, channel1_ena=1 and channel1_pitch=89; channel2_ena=0.
REQ-031 Press key5, then key7 -> voice1=52 and voice2=44, both enabled. Release key5 -> channel1_ena=0, channel1_pitch holds 52, channel2 unchanged.
REQ-032 keys 0,1,2 rise in the same cycle, steal disabled -> voice1=89, then voice2=79 one cycle later; next cycle dropped=1 for one cycle.
REQ-033 Same as REQ-032 with steal enabled -> on the third service cycle, voice1 is reassigned to key2: channel1_pitch=70, channel1_ena stays 1, dropped=0.
REQ-034 Press key3 and release it before service -> no enable change and no dropped pulse. Separately, assert rst with two events pending -> all outputs 0 and no events serviced after reset release.
